alu_arbiter: RTL

Shares the single-cycle datapath ALU between two requesters (e.g. the core's execute stage and a debug or coprocessor port). The block arbitrates round-robin, registers the winning operands and control, and drives them into the ALU. It captures ALUResult, Zero and Negative one cycle later and returns them to the winner over a valid/ready response channel. It sits between the requesters and the existing `alu` instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Lets two requesters share the single-cycle datapath ALU. Requests are
// arbitrated round-robin. The winning operands and control code are
// registered and driven into the ALU. The ALU outputs are captured one cycle
// later and returned to the winner over a valid/ready response channel.
// Only one operation is in flight at a time.
//
// Parameters
//   WIDTH        operand/result width, must match the ALU
//   CTRLW        ALUControl width
//
// Ports
//   clk                      system clock, all state on the rising edge
//   reset                    synchronous, active-high
//   ReqValid0/1      in      requester i has an operation pending
//   ReqReady0/1      out     request i accepted this cycle
//   ReqSrcA0/1       in      operand A of requester i
//   ReqSrcB0/1       in      operand B of requester i
//   ReqCtrl0/1       in      ALUControl code of requester i (not decoded)
//   RspValid0/1      out     result for requester i is available
//   RspReady0/1      in      requester i takes the result
//   RspResult0/1     out     captured ALUResult
//   RspZero0/1       out     captured Zero flag
//   RspNegative0/1   out     captured Negative flag
//   SrcA, SrcB       out     registered operands to the ALU
//   ALUControl       out     registered control code to the ALU
//   ALUResult        in      combinational result from the ALU
//   Zero, Negative   in      combinational flags from the ALU
//   GrantId          out     owner of the current operation (valid outside IDLE)
//   OpCount          out     completed response handshakes, wraps silently
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CTRLW = 5
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             ReqValid0,
    input  logic             ReqValid1,
    output logic             ReqReady0,
    output logic             ReqReady1,
    input  logic [WIDTH-1:0] ReqSrcA0,
    input  logic [WIDTH-1:0] ReqSrcA1,
    input  logic [WIDTH-1:0] ReqSrcB0,
    input  logic [WIDTH-1:0] ReqSrcB1,
    input  logic [CTRLW-1:0] ReqCtrl0,
    input  logic [CTRLW-1:0] ReqCtrl1,

    output logic             RspValid0,
    output logic             RspValid1,
    input  logic             RspReady0,
    input  logic             RspReady1,
    output logic [WIDTH-1:0] RspResult0,
    output logic [WIDTH-1:0] RspResult1,
    output logic             RspZero0,
    output logic             RspZero1,
    output logic             RspNegative0,
    output logic             RspNegative1,

    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [CTRLW-1:0] ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero,
    input  logic             Negative,

    output logic             GrantId,
    output logic [15:0]      OpCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             last_grant;
    logic             grant_id;
    logic             winner;
    logic             any_req;
    logic             accept;
    logic             rsp_taken;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [CTRLW-1:0] alu_ctrl;

    logic             rsp_valid0;
    logic             rsp_valid1;
    logic [WIDTH-1:0] rsp_result0;
    logic [WIDTH-1:0] rsp_result1;
    logic             rsp_zero0;
    logic             rsp_zero1;
    logic             rsp_neg0;
    logic             rsp_neg1;

    logic [15:0]      op_count;

    // Round-robin pick: a lone requester always wins; when both ask, the one
    // that did not win last time goes first. With no request the value is
    // unused.
    always_comb begin
        any_req = ReqValid0 | ReqValid1;
        if (ReqValid0 && ReqValid1) begin
            winner = ~last_grant;
        end else begin
            winner = ReqValid1;
        end
    end

    // Next-state and handshake decode. Ready is only ever offered in IDLE
    // and is held off while reset is high so nothing is accepted then.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        rsp_taken  = 1'b0;
        ReqReady0  = 1'b0;
        ReqReady1  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && !reset) begin
                    accept     = 1'b1;
                    ReqReady0  = ~winner;
                    ReqReady1  = winner;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = RESP;
            end
            RESP: begin
                // Only the owner's ready matters; the other side is ignored.
                rsp_taken = grant_id ? RspReady1 : RspReady0;
                if (rsp_taken) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. Operands load only on an accept so the ALU inputs
    // keep their last value between operations. A reset in ISSUE or RESP
    // drops the in-flight operation without producing a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_a       <= '0;
            src_b       <= '0;
            alu_ctrl    <= '0;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            rsp_valid0  <= 1'b0;
            rsp_valid1  <= 1'b0;
            rsp_result0 <= '0;
            rsp_result1 <= '0;
            rsp_zero0   <= 1'b0;
            rsp_zero1   <= 1'b0;
            rsp_neg0    <= 1'b0;
            rsp_neg1    <= 1'b0;
            op_count    <= '0;
        end else begin
            if (accept) begin
                src_a      <= winner ? ReqSrcA1 : ReqSrcA0;
                src_b      <= winner ? ReqSrcB1 : ReqSrcB0;
                alu_ctrl   <= winner ? ReqCtrl1 : ReqCtrl0;
                grant_id   <= winner;
                last_grant <= winner;
            end

            // The ALU has been looking at the registered operands for the
            // whole ISSUE cycle, so its outputs are settled at this edge.
            if (state == ISSUE) begin
                if (grant_id) begin
                    rsp_result1 <= ALUResult;
                    rsp_zero1   <= Zero;
                    rsp_neg1    <= Negative;
                    rsp_valid1  <= 1'b1;
                end else begin
                    rsp_result0 <= ALUResult;
                    rsp_zero0   <= Zero;
                    rsp_neg0    <= Negative;
                    rsp_valid0  <= 1'b1;
                end
            end

            if (rsp_taken) begin
                if (grant_id) begin
                    rsp_valid1 <= 1'b0;
                end else begin
                    rsp_valid0 <= 1'b0;
                end
                op_count <= op_count + 16'd1;
            end
        end
    end

    assign SrcA         = src_a;
    assign SrcB         = src_b;
    assign ALUControl   = alu_ctrl;
    assign GrantId      = grant_id;
    assign OpCount      = op_count;

    assign RspValid0    = rsp_valid0;
    assign RspValid1    = rsp_valid1;
    assign RspResult0   = rsp_result0;
    assign RspResult1   = rsp_result1;
    assign RspZero0     = rsp_zero0;
    assign RspZero1     = rsp_zero1;
    assign RspNegative0 = rsp_neg0;
    assign RspNegative1 = rsp_neg1;

endmodule
